// File: rtl/rv_decode_pkg.sv
// Shared encodings for the RV32I/RV64I integer decode-and-issue unit:
// major opcodes, funct fields, ALU operation codes and the issue FSM states.
package rv_decode_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SRL  = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_OPERAND   = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4
   } state_e;

   // Operation selected by funct3 alone; the funct7=0x20 variants are patched by the decoder.
   function automatic alu_op_e base_op(input logic [2:0] funct3);
      case (funct3)
         F3_ADD:  return ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv_op_decode.sv
// Combinational decode of one instruction word into ALU op, operand-B source,
// immediate, register fields and an illegal flag.
module rv_op_decode
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output alu_op_e         alu_op,
   output logic            use_imm,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);
   localparam int UW  = 12 - SHW;
   // funct bits above the shift amount that select SRAI; narrower by one bit on RV64
   localparam logic [6:0] SRA_PAT = 7'b0100000 >> (SHW - 5);

   logic [6:0]      opcode;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [UW-1:0]   upper;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_sh;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign upper  = instr[31:20+SHW];
   assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_sh = {{(XLEN-SHW){1'b0}}, instr[20 +: SHW]};

   always_comb begin
      alu_op  = base_op(funct3);
      use_imm = 1'b0;
      imm     = imm_i;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_ALT) begin
               if (funct3 == F3_ADD)     alu_op  = ALU_SUB;
               else if (funct3 == F3_SR) alu_op  = ALU_SRA;
               else                      illegal = 1'b1;
            end else if (funct7 != F7_BASE) begin
               illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            use_imm = 1'b1;
            if (funct3 == F3_SLL) begin
               imm     = imm_sh;
               illegal = (upper != '0);
            end else if (funct3 == F3_SR) begin
               imm = imm_sh;
               if (upper == SRA_PAT[UW-1:0]) alu_op  = ALU_SRA;
               else if (upper != '0)         illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv_decode_issue.sv
// Multi-cycle RV32I/RV64I integer decode-and-issue unit: one instruction in flight,
// operands to an external ALU, result written back to the regfile.
module rv_decode_issue
   import rv_decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [4:0]       rf_rs1_addr,
   output logic [4:0]       rf_rs2_addr,
   input  logic [XLEN-1:0]  rf_rd_data1,
   input  logic [XLEN-1:0]  rf_rd_data2,
   output logic [3:0]       alu_opcode,
   output logic [XLEN-1:0]  alu_op_a,
   output logic [XLEN-1:0]  alu_op_b,
   output logic             alu_valid,
   input  logic [XLEN-1:0]  alu_result,
   output logic             rf_wr_en,
   output logic [4:0]       rf_wr_addr,
   output logic [XLEN-1:0]  rf_wr_data,
   output logic             illegal,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   // state        | meaning
   // ST_IDLE      | ready; capture instr and rs1/rs2 on handshake
   // ST_DECODE    | decode captured word; illegal drops back to idle
   // ST_OPERAND   | regfile data valid; latch ALU operands
   // ST_EXECUTE   | alu_valid high; latch result and rd
   // ST_WRITEBACK | rf_wr_en high when rd != x0; retire

   state_e          state;
   logic [31:0]     instr_q;
   logic            use_imm_q;
   logic [XLEN-1:0] imm_q;
   logic [4:0]      rd_q;

   logic [31:0]     dec_word;
   alu_op_e         dec_op;
   logic            dec_use_imm;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rs1;
   logic [4:0]      dec_rs2;
   logic [4:0]      dec_rd;
   logic            dec_illegal;

   // One decoder serves both the incoming word (register fields) and the captured word.
   assign dec_word = (state == ST_IDLE) ? instr : instr_q;

   rv_op_decode #(.XLEN(XLEN)) u_dec (
      .instr   (dec_word),
      .alu_op  (dec_op),
      .use_imm (dec_use_imm),
      .imm     (dec_imm),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2),
      .rd      (dec_rd),
      .illegal (dec_illegal)
   );

   assign instr_ready = (state == ST_IDLE);
   assign alu_valid   = (state == ST_EXECUTE);
   assign rf_wr_en    = (state == ST_WRITEBACK) && (rf_wr_addr != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         instr_q     <= '0;
         use_imm_q   <= 1'b0;
         imm_q       <= '0;
         rd_q        <= '0;
         rf_rs1_addr <= '0;
         rf_rs2_addr <= '0;
         alu_opcode  <= '0;
         alu_op_a    <= '0;
         alu_op_b    <= '0;
         rf_wr_addr  <= '0;
         rf_wr_data  <= '0;
         illegal     <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         cycle_count <= cycle_count + CNT_W'(1);
         illegal     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (instr_valid) begin
                  instr_q     <= instr;
                  rf_rs1_addr <= dec_rs1;
                  rf_rs2_addr <= dec_rs2;
                  state       <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_illegal) begin
                  illegal <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  alu_opcode <= dec_op;
                  use_imm_q  <= dec_use_imm;
                  imm_q      <= dec_imm;
                  rd_q       <= dec_rd;
                  state      <= ST_OPERAND;
               end
            end
            ST_OPERAND: begin
               alu_op_a <= rf_rd_data1;
               alu_op_b <= use_imm_q ? imm_q : rf_rd_data2;
               state    <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               rf_wr_data <= alu_result;
               rf_wr_addr <= rd_q;
               state      <= ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
               instr_count <= instr_count + CNT_W'(1);
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_decode_issue.sv
// Self-checking bench for rv_decode_issue: directed table, multi-cycle sequences
// and random instructions checked against an instruction-semantics model.
module tb_rv_decode_issue;

   localparam int XLEN  = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0]      instr = '0;
   logic             instr_valid = 1'b0;
   logic             instr_ready;
   logic [4:0]       rf_rs1_addr, rf_rs2_addr;
   logic [XLEN-1:0]  rf_rd_data1, rf_rd_data2;
   logic [3:0]       alu_opcode;
   logic [XLEN-1:0]  alu_op_a, alu_op_b;
   logic             alu_valid;
   logic [XLEN-1:0]  alu_result;
   logic             rf_wr_en;
   logic [4:0]       rf_wr_addr;
   logic [XLEN-1:0]  rf_wr_data;
   logic             illegal;
   logic [CNT_W-1:0] cycle_count, instr_count;

   rv_decode_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2), .alu_opcode(alu_opcode),
      .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_valid(alu_valid),
      .alu_result(alu_result), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
      .rf_wr_data(rf_wr_data), .illegal(illegal), .cycle_count(cycle_count),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Environment: register file and ALU around the DUT.
   logic [31:0] regs [32];
   assign rf_rd_data1 = regs[rf_rs1_addr];
   assign rf_rd_data2 = regs[rf_rs2_addr];

   always_comb begin
      alu_result = '0;
      case (alu_opcode)
         4'd0: alu_result = alu_op_a + alu_op_b;
         4'd1: alu_result = alu_op_a - alu_op_b;
         4'd2: alu_result = alu_op_a & alu_op_b;
         4'd3: alu_result = alu_op_a | alu_op_b;
         4'd4: alu_result = alu_op_a ^ alu_op_b;
         4'd5: alu_result = alu_op_a << alu_op_b[4:0];
         4'd6: alu_result = {31'd0, $signed(alu_op_a) < $signed(alu_op_b)};
         4'd7: alu_result = {31'd0, alu_op_a < alu_op_b};
         4'd8: alu_result = $signed(alu_op_a) >>> alu_op_b[4:0];
         4'd9: alu_result = alu_op_a >> alu_op_b[4:0];
         default: alu_result = '0;
      endcase
   end

   int tb_cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) tb_cyc <= 0;
      else     tb_cyc <= tb_cyc + 1;
   end

   int n_vec = 0;
   int n_err = 0;
   int cur_idx = 0;
   int exp_ic = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, cur_idx, act, exp);
      end
   endtask

   typedef struct {
      logic        legal;
      logic [3:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      logic [31:0] w;
      exp_t        e;
   } vec_t;

   // Reference: RISC-V semantics of the instruction against the current register file.
   function automatic exp_t model(input logic [31:0] w);
      exp_t       e;
      logic [2:0] f3 = w[14:12];
      logic [6:0] f7 = w[31:25];
      logic       alt = 1'b0;
      e.legal = 1'b0;
      e.opc   = 4'd0;
      e.rd    = w[11:7];
      e.a     = regs[w[19:15]];
      e.b     = 32'd0;
      e.res   = 32'd0;
      if (w[6:0] == 7'b0110011) begin
         e.b     = regs[w[24:20]];
         alt     = (f7 == 7'h20);
         e.legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      end else if (w[6:0] == 7'b0010011) begin
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.b     = {27'd0, w[24:20]};
            alt     = (f3 == 3'd5) && (f7 == 7'h20);
            e.legal = (f7 == 7'h00) || alt;
         end else begin
            e.b     = {{20{w[31]}}, w[31:20]};
            e.legal = 1'b1;
         end
      end
      case (f3)
         3'd0: if (alt) begin e.opc = 4'd1; e.res = e.a - e.b; end
               else     begin e.opc = 4'd0; e.res = e.a + e.b; end
         3'd1: begin e.opc = 4'd5; e.res = e.a << e.b[4:0]; end
         3'd2: begin e.opc = 4'd6; e.res = ($signed(e.a) < $signed(e.b)) ? 32'd1 : 32'd0; end
         3'd3: begin e.opc = 4'd7; e.res = (e.a < e.b) ? 32'd1 : 32'd0; end
         3'd4: begin e.opc = 4'd4; e.res = e.a ^ e.b; end
         3'd5: if (alt) begin e.opc = 4'd8; e.res = $signed(e.a) >>> e.b[4:0]; end
               else     begin e.opc = 4'd9; e.res = e.a >> e.b[4:0]; end
         3'd6: begin e.opc = 4'd3; e.res = e.a | e.b; end
         default: begin e.opc = 4'd2; e.res = e.a & e.b; end
      endcase
      return e;
   endfunction

   // Issue one instruction from a negedge and observe the five cycles after the accept edge.
   task automatic run_instr(input logic [31:0] w, input exp_t e);
      logic [4:0]  rdy_v, ill_v, av_v, we_v;
      logic [3:0]  opc_s;
      logic [31:0] a_s, b_s, wd_s;
      logic [4:0]  wa_s;
      int          guard = 0;
      rdy_v = '0; ill_v = '0; av_v = '0; we_v = '0;
      opc_s = '0; a_s = '0; b_s = '0; wd_s = '0; wa_s = '0;
      while (!instr_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_issue", 64'(instr_ready), 64'(1'b1));
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = $urandom;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rdy_v[c] = instr_ready;
         ill_v[c] = illegal;
         av_v[c]  = alu_valid;
         we_v[c]  = rf_wr_en;
         if (c == 2) begin
            opc_s = alu_opcode;
            a_s   = alu_op_a;
            b_s   = alu_op_b;
         end
         if (c == 3) begin
            wa_s = rf_wr_addr;
            wd_s = rf_wr_data;
            if (rf_wr_en && rf_wr_addr != 5'd0) regs[rf_wr_addr] = rf_wr_data;
         end
      end
      if (e.legal) begin
         exp_ic++;
         chk("ready_pattern", 64'(rdy_v), 64'(5'b10000));
         chk("illegal_pattern", 64'(ill_v), 64'(5'b00000));
         chk("alu_valid_pattern", 64'(av_v), 64'(5'b00100));
         chk("wr_en_pattern", 64'(we_v), (e.rd != 5'd0) ? 64'(5'b01000) : 64'(5'b00000));
         chk("alu_opcode", 64'(opc_s), 64'(e.opc));
         chk("alu_op_a", 64'(a_s), 64'(e.a));
         chk("alu_op_b", 64'(b_s), 64'(e.b));
         chk("rf_wr_addr", 64'(wa_s), 64'(e.rd));
         chk("rf_wr_data", 64'(wd_s), 64'(e.res));
      end else begin
         chk("ready_pattern", 64'(rdy_v), 64'(5'b11110));
         chk("illegal_pattern", 64'(ill_v), 64'(5'b00010));
         chk("alu_valid_pattern", 64'(av_v), 64'(5'b00000));
         chk("wr_en_pattern", 64'(we_v), 64'(5'b00000));
      end
      chk("instr_count", 64'(instr_count), 64'(exp_ic[CNT_W-1:0]));
      chk("cycle_count", 64'(cycle_count), 64'(tb_cyc[CNT_W-1:0]));
      cur_idx++;
   endtask

   vec_t tbl [9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] rdy_seq, we_seq;
      logic [31:0] w;
      exp_t        e;

      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[1] = 32'd5;
      regs[2] = 32'd7;

      tbl[0] = '{32'h002081B3, '{1'b1, 4'd0, 32'd5, 32'd7, 32'd12, 5'd3}};
      tbl[1] = '{32'hFFF00293, '{1'b1, 4'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5}};
      tbl[2] = '{32'h402081B3, '{1'b1, 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 5'd3}};
      tbl[3] = '{32'h00115313, '{1'b1, 4'd9, 32'd7, 32'd1, 32'd3, 5'd6}};
      tbl[4] = '{32'h4040D093, '{1'b1, 4'd8, 32'd5, 32'd4, 32'd0, 5'd1}};
      tbl[5] = '{32'hFFFFFFFF, '{1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0}};
      tbl[6] = '{32'h4020C1B3, '{1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0}};
      tbl[7] = '{32'h02009093, '{1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0}};
      tbl[8] = '{32'h00208033, '{1'b1, 4'd0, 32'd0, 32'd7, 32'd7, 5'd0}};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_instr_ready", 64'(instr_ready), 64'(1'b1));
      chk("rst_counts", 64'({cycle_count, instr_count}), 64'(0));
      chk("rst_strobes", 64'({alu_valid, rf_wr_en, illegal}), 64'(0));
      chk("rst_operands", 64'({alu_op_a, alu_op_b}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("cycle_count_first", 64'(cycle_count), 64'(1));

      // Directed table
      for (int i = 0; i < 9; i++) run_instr(tbl[i].w, tbl[i].e);

      // Back-to-back: valid held high, second accept exactly five clocks after the first
      w = 32'h002081B3;
      e = model(w);
      instr       = w;
      instr_valid = 1'b1;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) @(negedge clk);
         rdy_seq[c] = instr_ready;
         we_seq[c]  = rf_wr_en;
         if (c == 9) chk("b2b_wr_data", 64'(rf_wr_data), 64'(e.res));
         if (c == 6) instr_valid = 1'b0;
      end
      regs[3] = e.res;
      exp_ic += 2;
      chk("b2b_ready_seq", 64'(rdy_seq), 64'(11'b10000100001));
      chk("b2b_wr_en_seq", 64'(we_seq), 64'(11'b01000010000));
      chk("b2b_instr_count", 64'(instr_count), 64'(exp_ic[CNT_W-1:0]));

      // Random instructions against the semantics model
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      for (int n = 0; n < 600; n++) begin
         int unsigned kind = $urandom_range(0, 9);
         int unsigned f7k  = $urandom_range(0, 2);
         w = $urandom;
         if (kind <= 3)      w[6:0] = 7'b0110011;
         else if (kind <= 7) w[6:0] = 7'b0010011;
         else if (kind == 8) w[6:0] = 7'($urandom_range(0, 127));
         if (f7k == 0)      w[31:25] = 7'h00;
         else if (f7k == 1) w[31:25] = 7'h20;
         e = model(w);
         run_instr(w, e);
      end

      // Asynchronous reset while the instruction is in EXECUTE
      w = 32'h002081B3;
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_alu_valid", 64'(alu_valid), 64'(1'b1));
      #1;
      rst = 1'b1;
      #1;
      exp_ic = 0;
      chk("async_rst_ready", 64'(instr_ready), 64'(1'b1));
      chk("async_rst_strobes", 64'({alu_valid, rf_wr_en, illegal}), 64'(0));
      chk("async_rst_counts", 64'({cycle_count, instr_count}), 64'(0));
      chk("async_rst_regs", 64'({alu_op_a, rf_wr_data}), 64'(0));
      chk("async_rst_fields", 64'({alu_opcode, rf_wr_addr, rf_rs1_addr}), 64'(0));
      repeat (2) @(negedge clk);
      chk("in_rst_wr_en", 64'(rf_wr_en), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(instr_ready), 64'(1'b1));
      chk("post_rst_wr_en", 64'(rf_wr_en), 64'(0));
      chk("post_rst_instr_count", 64'(instr_count), 64'(0));
      e = model(w);
      run_instr(w, e);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
